// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared types for the market-order table and its command scheduler
package ob_pkg;

    typedef logic [7:0]  uid_t;
    typedef logic [15:0] quantity_t;
    typedef logic [15:0] price_t;
    typedef logic [19:0] accum_quantity_t;

    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t qty;
    } table_t;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_CANCEL = 2'd1,
        OP_QUERY  = 2'd2,
        OP_RSVD   = 2'd3
    } sched_op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_FULL    = 2'd1,
        ST_MISS    = 2'd2,
        ST_TIMEOUT = 2'd3
    } sched_status_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_QRY_WAIT = 2'd2,
        S_RESP     = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ob_mk_table_sched_arb.sv
// rtl/ob_mk_table_sched_arb.sv - two-way round-robin arbiter, pointer favours requester 0 out of reset
module ob_mk_table_sched_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] vld_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic prefer_b_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (vld_i == 2'b11) begin
                gnt_o = prefer_b_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = vld_i;
            end
        end
    end

    // After a grant to A, B becomes the preferred side and vice versa.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prefer_b_q <= 1'b0;
        end else if (|gnt_o) begin
            prefer_b_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/ob_mk_table_sched.sv
// rtl/ob_mk_table_sched.sv - order-table command scheduler; OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN adds a query timeout
module ob_mk_table_sched
    import ob_pkg::*;
#(
    parameter int N           = 16,
    parameter int QRY_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_vld,
    output logic            a_rdy,
    input  sched_op_t       a_op,
    input  table_t          a_tbl,
    input  logic            b_vld,
    output logic            b_rdy,
    input  sched_op_t       b_op,
    input  table_t          b_tbl,
    input  logic            head_busy,
    output logic            head_lock,
    input  logic            tbl_full_w,
    output logic            tbl_insert,
    output table_t          tbl_insert_tbl,
    output logic            tbl_cancel,
    output uid_t            tbl_cancel_uid,
    input  logic            tbl_cancel_hit_w,
    input  table_t          tbl_cancel_hit_tbl_w,
    output logic            tbl_qry_vld,
    input  logic            tbl_qry_rsp_vld_r,
    input  accum_quantity_t tbl_qry_rsp_qty_r,
    output logic            rsp_vld,
    output logic            rsp_src,
    output logic [1:0]      rsp_status,
    output table_t          rsp_tbl,
    output accum_quantity_t rsp_qty
);

    if (N < 1 || QRY_TIMEOUT < 1) begin : g_param_chk
        $error("ob_mk_table_sched: N and QRY_TIMEOUT must be positive");
    end

    sched_state_t    state_q, state_d;
    sched_op_t       op_q, op_d, cmd_op;
    sched_status_t   st_q, st_d;
    table_t          pl_q, pl_d, cmd_tbl, rtbl_q, rtbl_d;
    accum_quantity_t rqty_q, rqty_d;
    logic            src_q, src_d, full_q;
    logic            ins_q, ins_d, canc_q, canc_d, qry_q, qry_d;
    logic [1:0]      gnt;
    logic            accept_en, accept;

`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(QRY_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Grants are gated by rst so a_rdy/b_rdy stay low while reset is held.
    assign accept_en = (state_q == S_IDLE) && !head_busy && !rst;

    ob_mk_table_sched_arb u_arb (
        .clk_i (clk),
        .rst_i (rst),
        .vld_i ({b_vld, a_vld}),
        .en_i  (accept_en),
        .gnt_o (gnt)
    );

    assign a_rdy   = gnt[0];
    assign b_rdy   = gnt[1];
    assign accept  = |gnt;
    assign cmd_op  = gnt[1] ? b_op  : a_op;
    assign cmd_tbl = gnt[1] ? b_tbl : a_tbl;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        st_d    = st_q;
        pl_d    = pl_q;
        src_d   = src_q;
        rtbl_d  = rtbl_q;
        rqty_d  = rqty_q;
        ins_d   = 1'b0;
        canc_d  = 1'b0;
        qry_d   = 1'b0;
`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    src_d  = gnt[1];
                    op_d   = cmd_op;
                    pl_d   = cmd_tbl;
                    rtbl_d = '0;
                    rqty_d = '0;
                    st_d   = ST_OK;
                    case (cmd_op)
                        OP_INSERT: begin
                            if (full_q) begin
                                st_d    = ST_FULL;
                                state_d = S_RESP;
                            end else begin
                                ins_d   = 1'b1;
                                state_d = S_ISSUE;
                            end
                        end
                        OP_CANCEL: begin
                            canc_d  = 1'b1;
                            state_d = S_ISSUE;
                        end
                        OP_QUERY: begin
                            qry_d   = 1'b1;
                            state_d = S_ISSUE;
                        end
                        default: begin
                            st_d    = ST_MISS;
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
                if (op_q == OP_CANCEL) begin
                    st_d   = tbl_cancel_hit_w ? ST_OK : ST_MISS;
                    rtbl_d = tbl_cancel_hit_w ? tbl_cancel_hit_tbl_w : '0;
                end else if (op_q == OP_QUERY) begin
                    state_d = S_QRY_WAIT;
`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_QRY_WAIT: begin
                if (tbl_qry_rsp_vld_r) begin
                    rqty_d  = tbl_qry_rsp_qty_r;
                    st_d    = ST_OK;
                    state_d = S_RESP;
`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(QRY_TIMEOUT)) begin
                    rqty_d  = '0;
                    st_d    = ST_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_INSERT;
            st_q    <= ST_OK;
            pl_q    <= '0;
            src_q   <= 1'b0;
            rtbl_q  <= '0;
            rqty_q  <= '0;
            full_q  <= 1'b0;
            ins_q   <= 1'b0;
            canc_q  <= 1'b0;
            qry_q   <= 1'b0;
`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            st_q    <= st_d;
            pl_q    <= pl_d;
            src_q   <= src_d;
            rtbl_q  <= rtbl_d;
            rqty_q  <= rqty_d;
            full_q  <= tbl_full_w;
            ins_q   <= ins_d;
            canc_q  <= canc_d;
            qry_q   <= qry_d;
`ifdef OB_MK_TABLE_SCHED_QRY_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Queries hold the lock from accept through RESP; a timed-out query has already let go.
    always_comb begin
        head_lock = 1'b0;
        case (state_q)
            S_IDLE:              head_lock = accept && (cmd_op == OP_QUERY);
            S_ISSUE, S_QRY_WAIT: head_lock = 1'b1;
            S_RESP:              head_lock = (op_q == OP_QUERY) && (st_q != ST_TIMEOUT);
            default:             head_lock = 1'b0;
        endcase
    end

    assign tbl_insert     = ins_q;
    assign tbl_cancel     = canc_q;
    assign tbl_qry_vld    = qry_q;
    assign tbl_insert_tbl = pl_q;
    assign tbl_cancel_uid = pl_q.uid;

    assign rsp_vld    = (state_q == S_RESP);
    assign rsp_src    = rsp_vld ? src_q  : 1'b0;
    assign rsp_status = rsp_vld ? st_q   : ST_OK;
    assign rsp_tbl    = rsp_vld ? rtbl_q : '0;
    assign rsp_qty    = rsp_vld ? rqty_q : '0;

endmodule

// File: tb/tb_ob_mk_table_sched.sv
// tb/tb_ob_mk_table_sched.sv - randomized bench for ob_mk_table_sched against a transaction-level model
module tb_ob_mk_table_sched;
    import ob_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_vld, a_rdy, b_vld, b_rdy;
    sched_op_t       a_op, b_op;
    table_t          a_tbl, b_tbl;
    logic            head_busy, head_lock, tbl_full_w;
    logic            tbl_insert, tbl_cancel, tbl_qry_vld;
    table_t          tbl_insert_tbl, tbl_cancel_hit_tbl_w, rsp_tbl;
    uid_t            tbl_cancel_uid;
    logic            tbl_cancel_hit_w, tbl_qry_rsp_vld_r;
    accum_quantity_t tbl_qry_rsp_qty_r, rsp_qty;
    logic            rsp_vld, rsp_src;
    logic [1:0]      rsp_status;

    always #5 clk = ~clk;

    ob_mk_table_sched dut (
        .clk(clk), .rst(rst),
        .a_vld(a_vld), .a_rdy(a_rdy), .a_op(a_op), .a_tbl(a_tbl),
        .b_vld(b_vld), .b_rdy(b_rdy), .b_op(b_op), .b_tbl(b_tbl),
        .head_busy(head_busy), .head_lock(head_lock), .tbl_full_w(tbl_full_w),
        .tbl_insert(tbl_insert), .tbl_insert_tbl(tbl_insert_tbl),
        .tbl_cancel(tbl_cancel), .tbl_cancel_uid(tbl_cancel_uid),
        .tbl_cancel_hit_w(tbl_cancel_hit_w), .tbl_cancel_hit_tbl_w(tbl_cancel_hit_tbl_w),
        .tbl_qry_vld(tbl_qry_vld), .tbl_qry_rsp_vld_r(tbl_qry_rsp_vld_r),
        .tbl_qry_rsp_qty_r(tbl_qry_rsp_qty_r),
        .rsp_vld(rsp_vld), .rsp_src(rsp_src), .rsp_status(rsp_status),
        .rsp_tbl(rsp_tbl), .rsp_qty(rsp_qty)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: absolute cycle numbers of every expected event.
    int              cyc = 0;
    int              free_at = 0, ins_at = -1, canc_at = -1, qry_at = -1, rsp_at = -1;
    int              lk_lo = -1, lk_hi = -1, qv_at = -1, qblk_lo = -1;
    bit              prefer_b = 1'b0, prev_full = 1'b0, e_ra, e_rb, e_src;
    table_t          e_pl, e_tbl;
    logic [1:0]      e_st;
    accum_quantity_t e_qty, q_qty;

    function automatic table_t rnd_tbl();
        table_t t;
        t.uid   = 8'($urandom);
        t.price = 16'($urandom);
        t.qty   = 16'($urandom);
        return t;
    endfunction

    task automatic step_drive(input bit allow_new);
        bit        gb;
        sched_op_t op;
        table_t    pl;
        a_vld = allow_new && ($urandom_range(0, 9) < 6);
        b_vld = allow_new && ($urandom_range(0, 9) < 6);
        a_op = sched_op_t'($urandom_range(0, 3));
        b_op = sched_op_t'($urandom_range(0, 3));
        a_tbl = rnd_tbl();
        b_tbl = rnd_tbl();
        head_busy = ($urandom_range(0, 3) == 0);
        tbl_full_w = ($urandom_range(0, 3) == 0);
        tbl_cancel_hit_w = 1'($urandom_range(0, 1));
        tbl_cancel_hit_tbl_w = rnd_tbl();
        tbl_qry_rsp_qty_r = accum_quantity_t'($urandom);
        if (cyc == qv_at) begin
            tbl_qry_rsp_vld_r = 1'b1;
            tbl_qry_rsp_qty_r = q_qty;
        end else if (cyc == qry_at) begin
            tbl_qry_rsp_vld_r = 1'b1;
        end else if (cyc >= qblk_lo && cyc < qv_at) begin
            tbl_qry_rsp_vld_r = 1'b0;
        end else begin
            tbl_qry_rsp_vld_r = 1'($urandom_range(0, 1));
        end

        if (cyc == canc_at) begin
            e_st  = tbl_cancel_hit_w ? 2'd0 : 2'd2;
            e_tbl = tbl_cancel_hit_w ? tbl_cancel_hit_tbl_w : '0;
        end

        e_ra = 1'b0;
        e_rb = 1'b0;
        if (cyc >= free_at && !head_busy && (a_vld || b_vld)) begin
            gb = b_vld && (!a_vld || prefer_b);
            prefer_b = !gb;
            e_ra = !gb;
            e_rb = gb;
            op = gb ? b_op : a_op;
            pl = gb ? b_tbl : a_tbl;
            e_src = gb;
            e_pl = pl;
            e_tbl = '0;
            e_qty = '0;
            e_st = 2'd0;
            lk_lo = -1;
            lk_hi = -1;
            case (op)
                OP_INSERT: begin
                    if (prev_full) begin
                        e_st = 2'd1;
                        rsp_at = cyc + 1;
                    end else begin
                        ins_at = cyc + 1;
                        rsp_at = cyc + 2;
                        lk_lo = cyc + 1;
                        lk_hi = cyc + 1;
                    end
                end
                OP_CANCEL: begin
                    canc_at = cyc + 1;
                    rsp_at = cyc + 2;
                    lk_lo = cyc + 1;
                    lk_hi = cyc + 1;
                end
                OP_QUERY: begin
                    qry_at = cyc + 1;
                    qblk_lo = cyc + 2;
                    qv_at = cyc + $urandom_range(2, 8);
                    q_qty = accum_quantity_t'($urandom);
                    e_qty = q_qty;
                    rsp_at = qv_at + 1;
                    lk_lo = cyc;
                    lk_hi = rsp_at;
                end
                default: begin
                    e_st = 2'd2;
                    rsp_at = cyc + 1;
                end
            endcase
            free_at = rsp_at + 1;
        end
        prev_full = tbl_full_w;
    endtask

    task automatic step_check();
        check_eq("a_rdy", a_rdy, e_ra);
        check_eq("b_rdy", b_rdy, e_rb);
        check_eq("tbl_insert", tbl_insert, cyc == ins_at);
        if (cyc == ins_at) check_eq("insert_tbl", tbl_insert_tbl, e_pl);
        check_eq("tbl_cancel", tbl_cancel, cyc == canc_at);
        if (cyc == canc_at) check_eq("cancel_uid", tbl_cancel_uid, e_pl.uid);
        check_eq("tbl_qry_vld", tbl_qry_vld, cyc == qry_at);
        check_eq("head_lock", head_lock, cyc >= lk_lo && cyc <= lk_hi);
        check_eq("rsp_vld", rsp_vld, cyc == rsp_at);
        if (cyc == rsp_at) begin
            check_eq("rsp_src", rsp_src, e_src);
            check_eq("rsp_status", rsp_status, e_st);
            check_eq("rsp_tbl", rsp_tbl, e_tbl);
            check_eq("rsp_qty", rsp_qty, e_qty);
        end
    endtask

    initial begin
        bit seen_rsp;
        a_vld = 1'b1; b_vld = 1'b1; a_op = OP_INSERT; b_op = OP_INSERT;
        a_tbl = '0; b_tbl = '0; head_busy = 1'b0; tbl_full_w = 1'b0;
        tbl_cancel_hit_w = 1'b0; tbl_cancel_hit_tbl_w = '0;
        tbl_qry_rsp_vld_r = 1'b0; tbl_qry_rsp_qty_r = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_a_rdy", a_rdy, 1'b0);
        check_eq("rst_b_rdy", b_rdy, 1'b0);
        check_eq("rst_head_lock", head_lock, 1'b0);
        check_eq("rst_rsp_vld", rsp_vld, 1'b0);
        check_eq("rst_tbl_ops", {tbl_insert, tbl_cancel, tbl_qry_vld}, 3'b000);
        a_vld = 1'b0;
        b_vld = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (2500) begin
            @(posedge clk);
            #1 step_drive(1'b1);
            @(negedge clk);
            step_check();
            cyc++;
        end
        repeat (20) begin
            @(posedge clk);
            #1 step_drive(1'b0);
            @(negedge clk);
            step_check();
            cyc++;
        end

        // Query left unanswered, then reset while it sits in QRY_WAIT.
        @(posedge clk);
        #1;
        a_vld = 1'b1; b_vld = 1'b0; a_op = OP_QUERY; head_busy = 1'b0; tbl_qry_rsp_vld_r = 1'b0;
        @(negedge clk);
        check_eq("rq_a_rdy", a_rdy, 1'b1);
        check_eq("rq_lock_accept", head_lock, 1'b1);
        @(posedge clk);
        #1 a_vld = 1'b0;
        @(negedge clk);
        check_eq("rq_qry_vld", tbl_qry_vld, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check_eq("rq_lock_wait", head_lock, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rq_rst_lock", head_lock, 1'b0);
        check_eq("rq_rst_rsp_vld", rsp_vld, 1'b0);
        check_eq("rq_rst_qry_vld", tbl_qry_vld, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_vld = 1'b1;
        b_vld = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ptr_a", a_rdy, 1'b1);
        check_eq("post_rst_ptr_b", b_rdy, 1'b0);
        @(posedge clk);
        #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        seen_rsp = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_rsp = seen_rsp | rsp_vld;
        end
        check_eq("no_rsp_after_rst", seen_rsp, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
